uart_byte_rx: RTL
=================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rx_valid  output  1  one-cycle pulse, rx_byte holds a good byte; no back-pressure; drives uart_frame_rx rx_valid directly.
REQ-006 SHALL have port rx_byte  output  8  last received byte; held stable until the next rx_valid.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-009 SHALL pass rxd through a 2-flop synchronizer (reset value 1) before any use; "line" below means the synchronizer output.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-011 IDLE: line==0 -> START, bit counter loaded with CLKS_PER_BIT/2-1 (integer division).
REQ-012 START: decrement each cycle; at 0 sample line: 0 -> DATA, counter=CLKS_PER_BIT-1, bit index=0; 1 -> IDLE, glitch rejected, no output pulse.
REQ-013 DATA: at counter 0 shift line into shift register bit [index], reload CLKS_PER_BIT-1, index++; after index 7 sampled -> STOP.
REQ-014 STOP: at counter 0 sample line: 1 -> rx_byte<=shift register, rx_valid=1 for exactly the next cycle, -> IDLE; 0 -> frame_err=1 for one cycle, rx_byte unchanged, -> WAIT_IDLE.
REQ-015 WAIT_IDLE: remain until line==1, then -> IDLE (break or low line SHALL NOT create further bytes or errors).
REQ-016 rx_valid and frame_err SHALL never assert in the same cycle.
REQ-017 Latency: rx_valid SHALL assert 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rxd falling edge, i.e. mid-stop-bit, ±1 cycle.
REQ-018 A start bit arriving immediately after IDLE re-entry SHALL be accepted; back-to-back bytes with a 1-bit stop SHALL be received without loss.
REQ-019 Bit counter width SHALL be $clog2(CLKS_PER_BIT); index counter 3 bits; no wrap beyond defined reloads.

Reset
REQ-020 On rst_n low, SHALL asynchronously force state=IDLE, sync flops=1, counters=0, shift register=0, rx_byte=8'h00, rx_valid=0, frame_err=0, busy=0.
REQ-021 Reset mid-byte SHALL discard the partial byte; after release, reception resumes only on a new falling edge.
REQ-022 Reset deassertion SHALL be used synchronously internally (no output glitch on release).

Structure
REQ-023 SHALL place the state enum (rx_state_t) and the default CLKS_PER_BIT constant in shared package uart_pkg, also used by the transmitter.
REQ-024 SHALL instantiate one sub-module, uart_sync2 (parameterised reset value, 1-bit 2-flop synchronizer), reusable by other async inputs.
REQ-025 Target 120-250 lines RTL; no combinational path from rxd to any output.

Verification (CLKS_PER_BIT=16, bench drives rxd at bit boundaries)
REQ-026 Send 0xA5 -> exactly one rx_valid, rx_byte=8'hA5, frame_err=0, pulse about 154 cycles after start edge.
REQ-027 Send 12-byte frame A5 08 01 01..08 CRC back-to-back into uart_frame_rx -> 12 rx_valid pulses in order, frame_valid=1, crc_ok=1.
REQ-028 Low pulse of 6 cycles on idle line -> no rx_valid, no frame_err, busy returns to 0 by cycle 12.
REQ-029 Send 0x3C with stop bit low, hold line low 40 cycles, then high, then send 0x55 -> one frame_err pulse, no rx_valid for 0x3C, then rx_valid with 8'h55.
REQ-030 Assert rst_n low during bit 4 of 0xFF, release, send 0x12 -> no output for 0xFF, rx_byte=8'h12, all outputs 0 while in reset.
REQ-031 Sweep CLKS_PER_BIT in {4,16,868} with +/-2% bit-period skew on 0x00 and 0xFF -> correct byte each time.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // 100 MHz core clock / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for one asynchronous bit, with a selectable reset value.
// Latency: 2 clk cycles from i_d to o_q.
// Backpressure: none (level path).
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, forces both flops to RST_VAL
//   i_d   - asynchronous input
//   o_q   - synchronized output
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver, LSB first, mid-bit sampling with start-bit glitch rejection.
// Latency: rx_valid 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rxd falling edge.
// Backpressure: none; rx_valid / frame_err are single-cycle pulses that must be consumed when seen.
//   clk       - system clock
//   rst_n     - asynchronous active-low reset (released synchronously inside)
//   rxd       - asynchronous serial line, idle high
//   rx_valid  - one-cycle pulse, rx_byte holds a good byte
//   rx_byte   - last good byte, held until the next rx_valid
//   frame_err - one-cycle pulse, stop bit sampled low
//   busy      - receiver not in IDLE
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       busy
);

    localparam int            CW          = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

    logic w_rst_n_int;
    logic w_line;
    logic w_cnt_zero;

    // Assert asynchronously, release on a clock edge so no flop leaves reset mid-cycle.
    uart_sync2 #(.RST_VAL(1'b0)) u_rst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (1'b1),
        .o_q   (w_rst_n_int)
    );

    uart_sync2 #(.RST_VAL(1'b1)) u_rxd_sync (
        .clk   (clk),
        .rst_n (w_rst_n_int),
        .i_d   (rxd),
        .o_q   (w_line)
    );

    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_byte;
    logic          r_rx_valid;
    logic          r_frame_err;
    logic          r_busy;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk or negedge w_rst_n_int) begin
        if (!w_rst_n_int) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_rx_byte   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_line) begin
                        r_state <= START;
                        r_cnt   <= HALF_RELOAD;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    // Re-check the line half a bit in: a short low pulse is dropped silently.
                    if (w_cnt_zero) begin
                        if (!w_line) begin
                            r_state <= DATA;
                            r_cnt   <= BIT_RELOAD;
                            r_idx   <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (w_cnt_zero) begin
                        r_shift[r_idx] <= w_line;
                        r_cnt          <= BIT_RELOAD;
                        if (r_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                STOP: begin
                    // Return to IDLE at mid-stop so a back-to-back start edge is not missed.
                    if (w_cnt_zero) begin
                        if (w_line) begin
                            r_rx_byte  <= r_shift;
                            r_rx_valid <= 1'b1;
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must go high before another start is looked for.
                    if (w_line) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_valid  = r_rx_valid;
    assign rx_byte   = r_rx_byte;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule
